// File: rtl/pwm_wave_pkg.sv
// rtl/pwm_wave_pkg.sv - shared types and width helper for the PWM waveform generator
package pwm_wave_pkg;

   typedef enum logic [1:0] {
      TRIANGLE  = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2,
      SQUARE    = 2'd3
   } wave_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } wave_state_t;

   localparam int DEFAULT_RESOLUTION = 16;

   // Duty values span 0..2^R inclusive, so they need one bit more than the PWM counter.
   function automatic int duty_width(input int resolution);
      return resolution + 1;
   endfunction

endpackage

// File: rtl/pwm_duty_seq.sv
// rtl/pwm_duty_seq.sv - duty value for a given period index, mode and burst length
module pwm_duty_seq
   import pwm_wave_pkg::*;
#(
   parameter int PWM_RESOLUTION = DEFAULT_RESOLUTION,
   parameter int D = 8,
   localparam int LW = $clog2(PWM_RESOLUTION + 1),
   localparam int DW = duty_width(PWM_RESOLUTION)
) (
   input  wave_mode_t      mode,
   input  logic [LW-1:0]   log_n,
   input  logic [D-1:0]    period,
   output logic [DW-1:0]   duty
);

   localparam logic [DW-1:0] FULL = {1'b1, {PWM_RESOLUTION{1'b0}}};

   logic [DW-1:0] n;
   logic [DW-1:0] h;
   logic [DW-1:0] kk;
   logic [LW-1:0] sh_ramp;
   logic [LW-1:0] sh_tri;

   always_comb begin
      n       = DW'(1) << log_n;
      h       = n >> 1;
      kk      = DW'(period);
      sh_ramp = LW'(PWM_RESOLUTION) - log_n;
      // Triangle climbs to full in N/2 periods, so its step is twice the ramp step.
      sh_tri  = sh_ramp + LW'(1);
      duty    = '0;
      if (log_n == '0) begin
         duty = FULL;
      end else begin
         case (mode)
            TRIANGLE:  duty = (kk <= h) ? (kk << sh_tri) : ((n - kk) << sh_tri);
            RAMP_UP:   duty = (kk + DW'(1)) << sh_ramp;
            RAMP_DOWN: duty = (n - kk) << sh_ramp;
            SQUARE:    duty = (kk < h) ? FULL : '0;
            default:   duty = '0;
         endcase
      end
   end

endmodule

// File: rtl/pwm_wave_gen.sv
// rtl/pwm_wave_gen.sv - triggered multi-mode PWM burst generator with abort and status
module pwm_wave_gen
   import pwm_wave_pkg::*;
#(
   parameter int PWM_RESOLUTION = DEFAULT_RESOLUTION,
   parameter int D = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         trigger_in,
   input  logic [D-1:0] duration_in,
   input  logic [1:0]   mode_in,
   input  logic         abort_in,
   output logic         waveform_out,
   output logic         busy_out,
   output logic         done_out
);

   localparam int R  = PWM_RESOLUTION;
   localparam int LW = $clog2(PWM_RESOLUTION + 1);
   localparam int DW = duty_width(PWM_RESOLUTION);

   wave_state_t   state, state_nx;
   wave_mode_t    mode_q, seq_mode;
   logic [LW-1:0] log_q, log_in, seq_log;
   logic [R-1:0]  count, count_nx;
   logic [D-1:0]  period, period_nx, seq_period, last_period;
   logic [DW-1:0] duty;
   logic          trig_prev, accept, last, wave_nx;

   always_comb begin
      log_in = '0;
      for (int i = 0; i < D; i++) begin
         if (duration_in[i]) log_in = LW'(i);
      end
   end

   assign accept      = (state == IDLE) && trigger_in && !trig_prev && !abort_in && (duration_in != '0);
   assign last_period = (D'(1) << log_q) - D'(1);
   assign last        = (period == last_period) && (count == '1);
   assign count_nx    = count + R'(1);
   assign period_nx   = (count == '1) ? period + D'(1) : period;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (abort_in) state_nx = IDLE;
                  else if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // The output is registered, so the duty is looked up for the count about to be shown.
   assign seq_mode   = (state == RUN) ? mode_q : wave_mode_t'(mode_in);
   assign seq_log    = (state == RUN) ? log_q : log_in;
   assign seq_period = (state == RUN) ? period_nx : '0;

   pwm_duty_seq #(
      .PWM_RESOLUTION (PWM_RESOLUTION),
      .D              (D)
   ) u_duty_seq (
      .mode   (seq_mode),
      .log_n  (seq_log),
      .period (seq_period),
      .duty   (duty)
   );

   always_comb begin
      wave_nx = 1'b0;
      if (accept)                                  wave_nx = (duty != '0);
      else if (state == RUN && !abort_in && !last) wave_nx = ({1'b0, count_nx} < duty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_prev    <= 1'b0;
         mode_q       <= TRIANGLE;
         log_q        <= '0;
         count        <= '0;
         period       <= '0;
         waveform_out <= 1'b0;
      end else begin
         trig_prev    <= trigger_in;
         waveform_out <= wave_nx;
         if (accept) begin
            mode_q <= wave_mode_t'(mode_in);
            log_q  <= log_in;
            count  <= '0;
            period <= '0;
         end else if (state == RUN) begin
            count  <= count_nx;
            period <= period_nx;
         end
      end
   end

   assign busy_out = (state == RUN);
   assign done_out = (state == DONE);

endmodule

// File: tb/tb_pwm_wave_gen.sv
// tb/tb_pwm_wave_gen.sv - self-checking bench for pwm_wave_gen with a queue-based burst model
module tb_pwm_wave_gen;

   localparam int R  = 4;
   localparam int DB = 4;
   localparam int P  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          trigger = 1'b0;
   logic          abort = 1'b0;
   logic [DB-1:0] duration = '0;
   logic [1:0]    mode = '0;
   logic          waveform, busy, done;

   int passed = 0;
   int total  = 0;
   int busy_cnt, done_cnt;
   int hi [8];
   logic [2:0] hidx;

   int m_state;
   bit m_prev, m_edge;
   bit q [$];
   bit e_wave, e_busy, e_done;

   pwm_wave_gen #(
      .PWM_RESOLUTION (R),
      .D              (DB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .trigger_in   (trigger),
      .duration_in  (duration),
      .mode_in      (mode),
      .abort_in     (abort),
      .waveform_out (waveform),
      .busy_out     (busy),
      .done_out     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Expected bit stream of a whole burst, straight from the duty formulas.
   task automatic build(input int dur, input int md);
      int n = 1;
      int h, st_r, st_t, d;
      while (n * 2 <= dur) n = n * 2;
      h    = n / 2;
      st_r = P / n;
      st_t = (h > 0) ? P / h : 0;
      q.delete();
      for (int k = 0; k < n; k++) begin
         case (md)
            0:       d = (k <= h) ? k * st_t : (n - k) * st_t;
            1:       d = (k + 1) * st_r;
            2:       d = (n - k) * st_r;
            default: d = (k < h) ? P : 0;
         endcase
         if (n == 1) d = P;
         for (int c = 0; c < P; c++) q.push_back(c < d);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0;
         m_prev  = 1'b0;
         q.delete();
         e_wave  = 1'b0;
         e_busy  = 1'b0;
         e_done  = 1'b0;
      end else begin
         m_edge = trigger && !m_prev;
         m_prev = trigger;
         e_wave = 1'b0;
         e_busy = 1'b0;
         e_done = 1'b0;
         case (m_state)
            0: if (m_edge && !abort && duration != 0) begin
                  build(int'(duration), int'(mode));
                  e_wave  = q.pop_front();
                  e_busy  = 1'b1;
                  m_state = 1;
               end
            1: if (abort) begin
                  m_state = 0;
                  q.delete();
               end else if (q.size() == 0) begin
                  m_state = 2;
                  e_done  = 1'b1;
               end else begin
                  e_wave = q.pop_front();
                  e_busy = 1'b1;
               end
            default: m_state = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("waveform", int'(waveform), int'(e_wave));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      if (busy) begin
         if (busy_cnt / P < 8) begin
            hidx = 3'(busy_cnt / P);
            hi[hidx] += int'(waveform);
         end
         busy_cnt++;
      end
      if (done) done_cnt++;
   end

   task automatic clr();
      busy_cnt = 0;
      done_cnt = 0;
      foreach (hi[i]) hi[i] = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic fire(input int dur, input int md);
      @(negedge clk);
      duration = DB'(dur);
      mode     = 2'(md);
      trigger  = 1'b1;
      @(negedge clk);
      trigger  = 1'b0;
   endtask

   task automatic burst(input string tag, input int h0, input int h1, input int h2, input int h3,
                        input int bexp, input int dexp);
      chk({tag, "_hi0"}, hi[0], h0);
      chk({tag, "_hi1"}, hi[1], h1);
      chk({tag, "_hi2"}, hi[2], h2);
      chk({tag, "_hi3"}, hi[3], h3);
      chk({tag, "_busy_len"}, busy_cnt, bexp);
      chk({tag, "_done_cnt"}, done_cnt, dexp);
   endtask

   initial begin
      int seen;
      clr();
      cycles(3);
      chk("reset_wave", int'(waveform), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      rst_n = 1'b1;
      cycles(2);

      clr(); fire(4, 0); cycles(80);
      burst("tri", 0, 8, 16, 8, 64, 1);

      clr(); fire(4, 1);
      mode = 2'd3; duration = 4'd1;
      cycles(80);
      burst("rampup", 4, 8, 12, 16, 64, 1);

      clr(); fire(4, 2); cycles(80);
      burst("rampdown", 16, 12, 8, 4, 64, 1);

      clr(); fire(6, 3); cycles(80);
      burst("square", 16, 16, 0, 0, 64, 1);

      clr(); fire(0, 0); cycles(30);
      burst("dur0", 0, 0, 0, 0, 0, 0);

      clr();
      @(negedge clk);
      duration = 4'd1; mode = 2'd0; trigger = 1'b1;
      cycles(60);
      trigger = 1'b0;
      cycles(5);
      burst("held", 16, 0, 0, 0, 16, 1);

      clr(); fire(4, 0); cycles(10);
      trigger = 1'b1; cycles(1); trigger = 1'b0;
      cycles(70);
      burst("edge_run", 0, 8, 16, 8, 64, 1);

      clr(); fire(2, 3);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("done_seen", seen, 1);
      trigger = 1'b1; cycles(3); trigger = 1'b0;
      cycles(40);
      burst("edge_done", 16, 0, 0, 0, 32, 1);

      clr();
      @(negedge clk);
      duration = 4'd4; mode = 2'd0; trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      cycles(19);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      cycles(10);
      burst("abort", 0, 4, 0, 0, 20, 0);
      clr(); fire(4, 0); cycles(80);
      burst("after_abort", 0, 8, 16, 8, 64, 1);

      clr(); fire(4, 2); cycles(5);
      chk("pre_reset_wave", int'(waveform), 1);
      chk("pre_reset_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_wave", int'(waveform), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      clr();
      cycles(40);
      burst("post_reset", 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
